// File: rtl/pu_pkg.sv
// Shared types and default sizing for the self-sequencing processing unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pu_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LANES_DEF      = 64;
  localparam int ACC_WIDTH_DEF  = 2*DATA_WIDTH_DEF + 8;
  localparam int MAX_OUT_DEF    = 32;
  localparam int MAX_CHUNKS_DEF = 16;
  localparam int W_DEPTH_DEF    = 128;

  localparam int OUT_W   = $clog2(MAX_OUT_DEF);
  localparam int CHUNK_W = $clog2(MAX_CHUNKS_DEF);
  localparam int WADDR_W = $clog2(W_DEPTH_DEF);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Travels with each weight read so S1/S2 know where the partial sum belongs.
  typedef struct packed {
    logic             vld;
    logic [OUT_W-1:0] o;
    logic             first;
    logic             last;
  } tag_t;

endpackage

// File: rtl/pu_dot.sv
// Signed LANES-wide dot product of one input chunk against one weight chunk.
// Latency: combinational.
// Backpressure: none.
module pu_dot #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 64,
  parameter int ACC_WIDTH  = 24
) (
  input  logic [LANES*DATA_WIDTH-1:0] a,
  input  logic [LANES*DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] dot
);

  logic signed [DATA_WIDTH-1:0]   ai;
  logic signed [DATA_WIDTH-1:0]   bi;
  logic signed [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    dot  = '0;
    ai   = '0;
    bi   = '0;
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      ai   = a[i*DATA_WIDTH +: DATA_WIDTH];
      bi   = b[i*DATA_WIDTH +: DATA_WIDTH];
      prod = ai * bi;
      dot  = dot + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/pu_seq.sv
// Dense layer slice engine: K chunks reused over N outputs, bias/ReLU, results to memory.
// Latency: done K*(N+1)+3 cycles after start with input always valid.
// Backpressure: in_ready only in WAIT_IN; input gaps stall the FSM, in-flight stages finish.
module pu_seq
  import pu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int MAX_OUT    = MAX_OUT_DEF,
  parameter int MAX_CHUNKS = MAX_CHUNKS_DEF,
  parameter int W_DEPTH    = W_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic [$clog2(MAX_CHUNKS)-1:0] cfg_num_chunks,
  input  logic [$clog2(MAX_OUT)-1:0]    cfg_num_out,
  input  logic                          cfg_add_bias,
  input  logic                          cfg_relu,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic                          w_wr_en,
  input  logic [$clog2(W_DEPTH)-1:0]    w_wr_addr,
  input  logic [LANES*DATA_WIDTH-1:0]   w_wr_data,
  input  logic                          b_wr_en,
  input  logic [$clog2(MAX_OUT)-1:0]    b_wr_addr,
  input  logic [DATA_WIDTH-1:0]         b_wr_data,
  input  logic                          r_rd_en,
  input  logic [$clog2(MAX_OUT)-1:0]    r_rd_addr,
  output logic [ACC_WIDTH-1:0]          r_rd_data
);

  localparam int CW = LANES*DATA_WIDTH;

  logic [CW-1:0]                  w_mem [W_DEPTH];
  logic [DATA_WIDTH-1:0]          b_mem [MAX_OUT];
  logic signed [ACC_WIDTH-1:0]    cache [MAX_OUT];
  logic [ACC_WIDTH-1:0]           r_mem [MAX_OUT];

  state_t                 state, state_nxt;
  logic [CHUNK_W-1:0]     k_q, num_chunks_q;
  logic [OUT_W-1:0]       o_q, num_out_q;
  logic [WADDR_W-1:0]     ptr_q;
  logic                   add_bias_q, relu_q, drain_q;
  logic [CW-1:0]          chunk_q;
  logic                   issue, accept, last_out, last_chunk;

  tag_t                        s1_tag;
  logic [CW-1:0]               s1_chunk, w_q;
  logic signed [ACC_WIDTH-1:0] dot, acc_in;
  logic                        s2_vld, s2_last;
  logic [OUT_W-1:0]            s2_o;
  logic signed [ACC_WIDTH-1:0] s2_sum, bias_ext, sum_b, res;

  assign last_out   = (o_q == num_out_q);
  assign last_chunk = (k_q == num_chunks_q);
  assign accept     = in_ready & in_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    issue     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (cfg_start) state_nxt = WAIT_IN;
      WAIT_IN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        issue = 1'b1;
        if (last_out) state_nxt = last_chunk ? DRAIN : WAIT_IN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_q) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q          <= '0;
      o_q          <= '0;
      ptr_q        <= '0;
      drain_q      <= 1'b0;
      num_chunks_q <= '0;
      num_out_q    <= '0;
      add_bias_q   <= 1'b0;
      relu_q       <= 1'b0;
    end else begin
      if (state == IDLE && cfg_start) begin
        num_chunks_q <= cfg_num_chunks;
        num_out_q    <= cfg_num_out;
        add_bias_q   <= cfg_add_bias;
        relu_q       <= cfg_relu;
        k_q          <= '0;
        ptr_q        <= '0;
      end
      if (accept) o_q <= '0;
      if (issue) begin
        ptr_q <= ptr_q + 1'b1;
        o_q   <= o_q + 1'b1;
        if (last_out && !last_chunk) k_q <= k_q + 1'b1;
      end
      drain_q <= (state == DRAIN) && !drain_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_tag  <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_o    <= '0;
    end else begin
      s1_tag  <= '{vld: issue, o: o_q, first: (k_q == '0), last: last_chunk};
      s2_vld  <= s1_tag.vld;
      s2_last <= s1_tag.last;
      s2_o    <= s1_tag.o;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) chunk_q <= in_data;
    if (issue) begin
      w_q      <= w_mem[ptr_q];
      s1_chunk <= chunk_q;
    end
    if (s1_tag.vld) s2_sum <= acc_in + dot;
  end

  pu_dot #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_dot (
    .a   (s1_chunk),
    .b   (w_q),
    .dot (dot)
  );

  // S2 may be writing the very cache entry S1 is about to read (N=1).
  always_comb begin
    acc_in = cache[s1_tag.o];
    if (s2_vld && !s2_last && s2_o == s1_tag.o) acc_in = s2_sum;
    if (s1_tag.first) acc_in = '0;
  end

  assign bias_ext = add_bias_q ?
      {{(ACC_WIDTH-DATA_WIDTH){b_mem[s2_o][DATA_WIDTH-1]}}, b_mem[s2_o]} : '0;
  assign sum_b = s2_sum + bias_ext;
  assign res   = (relu_q && sum_b[ACC_WIDTH-1]) ? '0 : sum_b;

  always_ff @(posedge clk) begin
    if (w_wr_en && !busy) w_mem[w_wr_addr] <= w_wr_data;
    if (b_wr_en && !busy) b_mem[b_wr_addr] <= b_wr_data;
    if (!rst && s2_vld && !s2_last) cache[s2_o] <= s2_sum;
    if (!rst && s2_vld && s2_last)  r_mem[s2_o] <= res;
  end

  always_ff @(posedge clk) begin
    if (rst)          r_rd_data <= '0;
    else if (r_rd_en) r_rd_data <= r_mem[r_rd_addr];
  end

endmodule

// File: tb/tb_pu_seq.sv
// Directed plus randomized runs of pu_seq checked against an arithmetic reference model.
module tb_pu_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [3:0]   cfg_num_chunks;
  logic [4:0]   cfg_num_out;
  logic         cfg_add_bias, cfg_relu;
  logic         busy, done;
  logic         in_valid, in_ready;
  logic [511:0] in_data;
  logic         w_wr_en;
  logic [6:0]   w_wr_addr;
  logic [511:0] w_wr_data;
  logic         b_wr_en;
  logic [4:0]   b_wr_addr;
  logic [7:0]   b_wr_data;
  logic         r_rd_en;
  logic [4:0]   r_rd_addr;
  logic [23:0]  r_rd_data;

  pu_seq dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_chunks(cfg_num_chunks),
    .cfg_num_out(cfg_num_out), .cfg_add_bias(cfg_add_bias), .cfg_relu(cfg_relu),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .r_rd_en(r_rd_en), .r_rd_addr(r_rd_addr), .r_rd_data(r_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [511:0] wm [128];
  int           bm [32];
  logic [511:0] ch [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [511:0] fill(input int v);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [511:0] rnd_chunk();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic int dotf(input logic [511:0] a, input logic [511:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 64; i++) s += int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
    return s;
  endfunction

  // Whole-layer result from the layout rule W[(k*N+o) mod 128], wrapped to 24 bits.
  function automatic int expect_res(input int k_n, input int n, input int o, input bit ab, input bit relu);
    longint     s;
    logic [23:0] t;
    int         r;
    s = 0;
    for (int k = 0; k < k_n; k++) s += dotf(ch[k], wm[(k*n + o) % 128]);
    if (ab) s += bm[o];
    t = s[23:0];
    r = int'($signed(t));
    if (relu && r < 0) r = 0;
    return r;
  endfunction

  task automatic wr_w(input int a, input logic [511:0] d);
    w_wr_en = 1'b1; w_wr_addr = 7'(a); w_wr_data = d;
    @(posedge clk); #1;
    w_wr_en = 1'b0;
    wm[a] = d;
  endtask

  task automatic wr_b(input int a, input int v);
    b_wr_en = 1'b1; b_wr_addr = 5'(a); b_wr_data = 8'(v);
    @(posedge clk); #1;
    b_wr_en = 1'b0;
    bm[a] = int'($signed(8'(v)));
  endtask

  task automatic run(input int k_n, input int n, input bit ab, input bit relu, input int stall,
                     input int abort_at, input int probe_cyc, input int probe_old);
    int cyc, idx, stall_left, pulses;
    bit acc;
    cfg_num_chunks = 4'(k_n - 1); cfg_num_out = 5'(n - 1);
    cfg_add_bias = ab; cfg_relu = relu; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cyc = 1; idx = 0; stall_left = stall;
    check("busy_after_start", 32'(busy), 1);
    check("in_ready_wait_in", 32'(in_ready), 1);
    while (cyc < 400) begin
      if (done) break;
      if (cyc == 3 && abort_at == 0) begin
        cfg_start = 1'b1; cfg_num_out = 5'($urandom);
        w_wr_en = 1'b1; w_wr_addr = 7'd0; w_wr_data = rnd_chunk();
        b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 8'($urandom);
      end else begin
        cfg_start = 1'b0; w_wr_en = 1'b0; b_wr_en = 1'b0;
      end
      r_rd_en = (cyc == probe_cyc);
      r_rd_addr = 5'd0;
      if (cyc == abort_at) begin
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        check("abort_rd_data", 32'(r_rd_data), 0);
        pulses = 0;
        repeat (30) begin
          @(posedge clk); #1;
          if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 0);
        return;
      end
      if (idx == 1 && in_ready && stall_left > 0) begin
        in_valid = 1'b0;
        stall_left--;
      end else begin
        in_valid = (idx < k_n);
        if (idx < k_n) in_data = ch[idx];
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      if (cyc - 1 == probe_cyc) check("same_cycle_read_old", 32'($signed(r_rd_data)), probe_old);
    end
    in_valid = 1'b0; r_rd_en = 1'b0; cfg_start = 1'b0; w_wr_en = 1'b0; b_wr_en = 1'b0;
    check("done_latency", 32'(cyc), k_n*(n+1) + 3 + stall);
    check("busy_low_at_done", 32'(busy), 0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 0);
    for (int o = 0; o < n; o++) begin
      r_rd_en = 1'b1; r_rd_addr = 5'(o);
      @(posedge clk); #1;
      check($sformatf("result_%0d", o), 32'($signed(r_rd_data)), expect_res(k_n, n, o, ab, relu));
    end
    r_rd_en = 1'b0;
  endtask

  initial begin
    int k_n, n;
    rst = 1'b1; cfg_start = 0; cfg_num_chunks = 0; cfg_num_out = 0; cfg_add_bias = 0; cfg_relu = 0;
    in_valid = 0; in_data = '0; w_wr_en = 0; w_wr_addr = 0; w_wr_data = '0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; r_rd_en = 0; r_rd_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_in_ready", 32'(in_ready), 0);
    check("reset_rd_data", 32'(r_rd_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single chunk, single output with bias: 64*1*2+5 = 133.
    wr_w(0, fill(2)); wr_b(0, 5);
    ch[0] = fill(1);
    run(1, 1, 1'b1, 1'b0, 0, 0, 0, 0);

    // Chunk reuse over 3 outputs; probe o=0 on the cycle it is rewritten.
    for (int o = 0; o < 3; o++) begin
      wr_w(o, fill(o + 1));
      wr_w(3 + o, fill(1));
    end
    ch[0] = fill(1); ch[1] = fill(-1);
    run(2, 3, 1'b0, 1'b0, 0, 0, 8, 133);

    // ReLU on and off.
    wr_w(0, fill(1)); wr_w(1, fill(1)); wr_b(0, 0); wr_b(1, 0);
    ch[0] = fill(-1);
    run(1, 2, 1'b1, 1'b1, 0, 0, 0, 0);
    run(1, 2, 1'b1, 1'b0, 0, 0, 0, 0);

    // Back-to-back accumulation on a single output.
    for (int a = 0; a < 4; a++) begin
      wr_w(a, fill(1));
      ch[a] = fill(1);
    end
    run(4, 1, 1'b0, 1'b0, 0, 0, 0, 0);

    // Input gap before the second chunk, then abort mid-run and recover.
    for (int o = 0; o < 3; o++) begin
      wr_w(o, fill(o + 1));
      wr_w(3 + o, fill(1));
    end
    ch[0] = fill(1); ch[1] = fill(-1);
    run(2, 3, 1'b0, 1'b0, 5, 0, 0, 0);
    run(2, 3, 1'b0, 1'b0, 0, 3, 0, 0);
    run(2, 3, 1'b0, 1'b0, 0, 0, 0, 0);

    // Randomized layers, the last one wrapping the weight pointer.
    for (int t = 0; t < 5; t++) begin
      k_n = (t == 4) ? 16 : int'($urandom_range(1, 6));
      n   = (t == 4) ? 10 : int'($urandom_range(1, 8));
      for (int a = 0; a < k_n*n && a < 128; a++) wr_w(a, rnd_chunk());
      for (int o = 0; o < n; o++) wr_b(o, int'($urandom_range(0, 255)));
      for (int k = 0; k < k_n; k++) ch[k] = rnd_chunk();
      run(k_n, n, 1'($urandom), 1'($urandom), (k_n > 1) ? int'($urandom_range(0, 3)) : 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pu_seq.md
Name: pu_seq

Overview:
- Self-sequencing processing unit: weight memory, bias memory, per-output accumulator cache, result memory and a control FSM in one block.
- One start command runs a full dense layer slice. The block accepts K input chunks over a valid/ready stream and reuses each chunk across N outputs. It adds optional bias and ReLU, then writes N results into result memory.
- Sits under the array controller. It replaces external cache/address sequencing of the current PU.

Parameters:
- DATA_WIDTH, 8, signed element width of data, weights and bias.
- LANES, 64, elements per chunk.
- ACC_WIDTH, 2*DATA_WIDTH+8, signed accumulator and result width.
- MAX_OUT, 32, maximum outputs N; sets cache, bias and result memory depth.
- MAX_CHUNKS, 16, maximum chunks K.
- W_DEPTH, 128, weight memory depth in chunk-words.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_start  in  1  start pulse; sampled only in IDLE.
- cfg_num_chunks  in  clog2(MAX_CHUNKS)  K-1.
- cfg_num_out  in  clog2(MAX_OUT)  N-1.
- cfg_add_bias  in  1  add bias on final chunk.
- cfg_relu  in  1  clamp negative results to 0.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle completion pulse.
- in_valid  in  1  input chunk valid.
- in_ready  out  1  block can accept a chunk.
- in_data  in  LANES*DATA_WIDTH  chunk; lane i at [i*DW +: DW].
- w_wr_en  in  1  weight write enable.
- w_wr_addr  in  clog2(W_DEPTH)  weight write address.
- w_wr_data  in  LANES*DATA_WIDTH  weight chunk.
- b_wr_en  in  1  bias write enable.
- b_wr_addr  in  clog2(MAX_OUT)  bias write address.
- b_wr_data  in  DATA_WIDTH  bias value.
- r_rd_en  in  1  result read enable.
- r_rd_addr  in  clog2(MAX_OUT)  result read address.
- r_rd_data  out  ACC_WIDTH  result; 1-cycle latency.

Behaviour:
- Reset: state IDLE; busy=0, done=0, in_ready=0, r_rd_data=0, all counters 0. Memory contents are not reset.
- Reset mid-run aborts immediately to IDLE and kills the pipeline. Partially written results remain in result memory.
- Weight layout: W[k*N+o] holds the weights for chunk k, output o. The address pointer walks linearly from 0 and wraps modulo W_DEPTH.
- FSM states and transitions:
  - IDLE: on cfg_start, latch the cfg fields, set k=0, ptr=0, go to WAIT_IN.
  - WAIT_IN: in_ready=1. On in_valid, latch the chunk, set o=0, go to RUN.
  - RUN: in_ready=0. Each cycle issue weight read at ptr with tag (o, k==0, k==K-1) and the chunk copy; increment ptr and o. When o==N-1: if k==K-1 go to DRAIN, else increment k and go to WAIT_IN.
  - DRAIN: wait 2 cycles for the pipeline to empty, then go to DONE.
  - DONE: done=1 for one cycle; busy drops in the same cycle; go to IDLE.
- Pipeline, 3 stages:
  - S0: weight address issue.
  - S1: weight data returns (synchronous read). Compute signed dot = sum of in*w over LANES. Read the cache at o, or use 0 if first chunk. Forward from S2 when S2 writes the same o; this is the N=1 case.
  - S2, not final chunk: cache[o] = acc + dot.
  - S2, final chunk: sum = acc + dot, plus sign-extended bias[o] if cfg_add_bias. Apply ReLU if cfg_relu. Write the result to result memory at o.
- Arithmetic: all signed; wraps at ACC_WIDTH with no saturation.
- Latency: with in_valid held high, done asserts exactly K*(N+1)+3 cycles after the cfg_start sampling cycle.
- Boundary conditions:
  - cfg_start while busy is ignored.
  - w_wr_en and b_wr_en while busy are ignored.
  - An in_valid gap in WAIT_IN stalls only the FSM; in-flight pipeline stages still complete.
  - A result read of an address written in the same cycle returns the old data.
  - K=1: bias/ReLU applies on the only chunk, and the cache is never written.

Decomposition:
- pu_pkg holds:
  - the state enum (IDLE, WAIT_IN, RUN, DRAIN, DONE);
  - the S1/S2 tag struct;
  - width localparams derived with clog2.
- One sub-module, pu_dot: combinational LANES-wide signed dot product producing ACC_WIDTH output.
- Memories are behavioural arrays inside pu_seq.

Test Plan:
- Single chunk, one output: K=1, N=1, all data=1, all weights=2, bias=5, add_bias=1 -> result[0]=133; done 5 cycles after start.
- Reuse and latency: K=2, N=3, chunk0 all 1, chunk1 all -1, weights W[o]=o+1 and W[3+o]=1 -> result[o]=64*(o+1)-64 = {0,64,128}; done at cycle 11.
- ReLU: K=1, N=2, data all -1, weights all 1, bias 0, relu=1 -> result {0,0}; relu=0 -> {-64,-64}.
- Forwarding: K=4, N=1, data all 1, weights all 1 -> result[0]=256.
- Stall: same as the reuse test with in_valid low for 5 cycles before chunk1 -> same results; done delayed by 5 cycles; cfg_start pulsed mid-run ignored.
- Reset mid-RUN: assert rst during chunk0 of the reuse test -> next cycle busy=0, in_ready=0, done never pulses; a new run then completes correctly.
